// File: rtl/gf_mult_seq.sv
// gf_mult_seq: iterative GF(2^WIDTH) multiplier.
// Computes y = a * b mod (x^WIDTH + POLY) with one Horner step per clock.
// The multiplier b is scanned MSB first. Each operand pair takes WIDTH RUN cycles.
// Input and output use valid/ready handshakes.
module gf_mult_seq #(
    parameter int                WIDTH = 8,
    parameter logic [WIDTH-1:0]  POLY  = WIDTH'(8'h1B)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] step_res;

    // Multiply by x and fold the overflow bit back through the reduction polynomial.
    function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
    endfunction

    // One Horner step: acc*x, plus a if the current multiplier bit is set.
    function automatic logic [WIDTH-1:0] horner_step(input logic [WIDTH-1:0] acc,
                                                     input logic [WIDTH-1:0] mcand,
                                                     input logic             bit_set);
        return xtime(acc) ^ (bit_set ? mcand : '0);
    endfunction

    // Datapath result of the current Horner step.
    always_comb begin
        step_res = horner_step(acc_q, a_q, b_q[cnt_q]);
    end

    // Next-state logic for the IDLE/RUN/DONE controller and the operand datapath.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = step_res;
                if (cnt_q == '0) begin
                    // Product register only changes when a new product completes.
                    y_d     = step_res;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                // No new operand is taken on the handshake edge; IDLE comes first.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight product.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign y         = y_q;

endmodule

// File: tb/tb_gf_mult_seq.sv
// Self-checking bench for gf_mult_seq: default AES field instance plus a GF(2^4) instance.
module tb_gf_mult_seq;

    logic       clk;
    logic       reset;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0] a8, b8, y8;

    logic       in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [3:0] a4, b4, y4;

    int n_checks;
    int n_fail;

    logic [15:0] exp_q[$];

    gf_mult_seq #(.WIDTH(8), .POLY(8'h1B)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .y(y8), .busy(busy8)
    );

    gf_mult_seq #(.WIDTH(4), .POLY(4'h3)) dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .y(y4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-serial reference: LSB-first shift-and-add with modular doubling of a.
    function automatic logic [15:0] gf_ref(input logic [15:0] ra, input logic [15:0] rb,
                                           input int w, input logic [15:0] poly);
        logic [15:0] p, aa, mask;
        logic        carry;
        mask = (16'h1 << w) - 16'h1;
        p    = '0;
        aa   = ra & mask;
        for (int i = 0; i < w; i++) begin
            if (rb[i]) p = p ^ aa;
            carry = aa[w-1];
            aa    = (aa << 1) & mask;
            if (carry) aa = aa ^ (poly & mask);
        end
        return p;
    endfunction

    // Drive one operand pair into dut8, wait for the product, then take it.
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib,
                        output logic [7:0] oy, output int lat);
        int guard;
        guard = 0;
        while (!in_ready8 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        a8 = ia; b8 = ib; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        while (!out_valid8 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        oy = y8;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic run4(input logic [3:0] ia, input logic [3:0] ib,
                        output logic [3:0] oy, output int lat);
        int guard;
        guard = 0;
        while (!in_ready4 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        a4 = ia; b4 = ib; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        lat = 0;
        while (!out_valid4 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        oy = y4;
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0 || y8 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset8: in_ready=%b out_valid=%b busy=%b y=%h, required 1 0 0 00",
                     in_ready8, out_valid8, busy8, y8);
        end
        n_checks++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || busy4 !== 1'b0 || y4 !== 4'h0) begin
            n_fail++;
            $display("FAIL reset4: in_ready=%b out_valid=%b busy=%b y=%h, required 1 0 0 0",
                     in_ready4, out_valid4, busy4, y4);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0]  yv;
        logic [15:0] e;
        int          lat;
        exp_q.push_back(16'h00D6);
        run8(8'h6B, 8'h02, yv, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles, required 8", lat);
        end
        n_checks++;
        if (yv !== e[7:0]) begin
            n_fail++;
            $display("FAIL basic_6Bx02: got %h, required %h", yv, e[7:0]);
        end
        n_checks++;
        if (in_ready8 !== 1'b1 || busy8 !== 1'b0 || out_valid8 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after_hs: in_ready=%b busy=%b out_valid=%b, required 1 0 0",
                     in_ready8, busy8, out_valid8);
        end
        exp_q.push_back(16'h0056);
        run8(8'h2B, 8'h02, yv, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (yv !== e[7:0] || lat !== 8) begin
            n_fail++;
            $display("FAIL basic_2Bx02: got %h lat %0d, required %h lat 8", yv, lat, e[7:0]);
        end
    endtask

    task automatic test_fips();
        logic [7:0]  va[5] = '{8'h57, 8'h57, 8'h83, 8'h00, 8'hA5};
        logic [7:0]  vb[5] = '{8'h83, 8'h13, 8'h57, 8'hA5, 8'h01};
        logic [7:0]  vy[5] = '{8'hC1, 8'hFE, 8'hC1, 8'h00, 8'hA5};
        logic [7:0]  yv;
        logic [15:0] e;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({8'h00, vy[i]});
            run8(va[i], vb[i], yv, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (yv !== e[7:0] || lat !== 8) begin
                n_fail++;
                $display("FAIL fips_%h_x_%h: got %h lat %0d, required %h lat 8",
                         va[i], vb[i], yv, lat, e[7:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] yv;
        int         lat;
        a8 = 8'h57; b8 = 8'h83; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        n_checks++;
        if (out_valid8 !== 1'b1 || y8 !== 8'hC1) begin
            n_fail++;
            $display("FAIL bp_first: out_valid=%b y=%h, required 1 C1", out_valid8, y8);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1;
            end else begin
                in_valid8 = 1'b0;
            end
            @(posedge clk); #1;
            n_checks++;
            if (y8 !== 8'hC1 || in_ready8 !== 1'b0 || out_valid8 !== 1'b1 || busy8 !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: y=%h in_ready=%b out_valid=%b busy=%b, required C1 0 1 1",
                         i, y8, in_ready8, out_valid8, busy8);
            end
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        n_checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready8, out_valid8);
        end
        n_checks++;
        if (y8 !== 8'hC1) begin
            n_fail++;
            $display("FAIL bp_y_kept: got %h, required C1", y8);
        end
        run8(8'h02, 8'h03, yv, lat);
        n_checks++;
        if (yv !== 8'h06) begin
            n_fail++;
            $display("FAIL bp_next: got %h, required 06", yv);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] yv;
        int         lat;
        a8 = 8'h57; b8 = 8'h83; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || y8 !== 8'h00 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: in_ready=%b out_valid=%b y=%h busy=%b, required 1 0 00 0",
                     in_ready8, out_valid8, y8, busy8);
        end
        repeat (10) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid8 !== 1'b0) begin
                n_fail++;
                $display("FAIL midrun_ghost: out_valid=%b after reset, required 0", out_valid8);
            end
        end
        run8(8'h57, 8'h13, yv, lat);
        n_checks++;
        if (yv !== 8'hFE || lat !== 8) begin
            n_fail++;
            $display("FAIL midrun_next: got %h lat %0d, required FE lat 8", yv, lat);
        end
    endtask

    task automatic test_width4();
        logic [3:0]  va[3] = '{4'h7, 4'hF, 4'h8};
        logic [3:0]  vb[3] = '{4'h9, 4'h1, 4'h2};
        logic [3:0]  vy[3] = '{4'hA, 4'hF, 4'h3};
        logic [3:0]  yv;
        logic [15:0] e;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({12'h000, vy[i]});
            run4(va[i], vb[i], yv, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (yv !== e[3:0] || lat !== 4) begin
                n_fail++;
                $display("FAIL w4_%h_x_%h: got %h lat %0d, required %h lat 4",
                         va[i], vb[i], yv, lat, e[3:0]);
            end
        end
    endtask

    task automatic test_random();
        int         sent, recv, cycles;
        logic [7:0] ra, rb;
        logic [15:0] e;
        sent = 0; recv = 0; cycles = 0;
        exp_q.delete();
        while (recv < 1000 && cycles < 60000) begin
            ra = 8'($urandom); rb = 8'($urandom);
            a8 = ra; b8 = rb;
            in_valid8  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            out_ready8 = ($urandom_range(0, 9) < 6);
            if (in_valid8 && in_ready8) begin
                exp_q.push_back(gf_ref({8'h00, ra}, {8'h00, rb}, 8, 16'h001B));
                sent++;
            end
            if (out_valid8 && out_ready8) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: result %h with no pending operands", y8);
                end else begin
                    e = exp_q.pop_front();
                    if (y8 !== e[7:0]) begin
                        n_fail++;
                        $display("FAIL rand_%0d: got %h, required %h", recv, y8, e[7:0]);
                    end
                end
                recv++;
            end
            @(posedge clk); #1;
            cycles++;
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b0;
        n_checks++;
        if (recv !== 1000 || sent !== 1000 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL rand_count: sent %0d received %0d pending %0d, required 1000 1000 0",
                     sent, recv, exp_q.size());
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;
        test_reset();
        test_basic();
        test_fips();
        test_backpressure();
        test_reset_mid_run();
        test_width4();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
